// File: rtl/countdown_timer.sv
// countdown_timer: BCD mm:ss countdown timer stepped by rising edges of a 1 Hz square wave.
// Optional feature: define COUNTDOWN_ALARM_EN to enable the post-expiry alarm toggle;
// without it the alarm output is tied low and no alarm counter exists.
module countdown_timer #(
   parameter logic [7:0] START_MIN  = 8'h01,
   parameter logic [7:0] START_SEC  = 8'h00,
   parameter int         ALARM_SECS = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clock_1,
   input  logic       start,
   input  logic       pause,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t     state_q;
   logic [7:0] min_q;
   logic [7:0] sec_q;
   logic       running_q;
   logic       done_q;
   logic       clk1_q;

   logic       sec_pulse_c;
   logic       tick_c;
   logic       load_ok_c;
   logic       time_zero_c;
   logic       dec_zero_c;
   logic [7:0] dec_min_c;
   logic [7:0] dec_sec_c;

   // One-clock pulse on each rising edge of the 1 Hz input
   assign sec_pulse_c = clock_1 & ~clk1_q;

   // A second only counts when no command occupies the cycle; otherwise it is dropped
   assign tick_c = sec_pulse_c & ~load & ~start & ~pause;

   // Load operands must be valid BCD minutes (00-99) and seconds (00-59)
   assign load_ok_c = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                      (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);

   assign time_zero_c = (min_q == 8'h00) && (sec_q == 8'h00);

   // One-second BCD decrement with borrow through seconds units, tens and minutes
   always_comb begin
      dec_min_c = min_q;
      dec_sec_c = sec_q;
      if (sec_q[3:0] != 4'd0) begin
         dec_sec_c[3:0] = sec_q[3:0] - 4'd1;
      end else if (sec_q[7:4] != 4'd0) begin
         dec_sec_c = {sec_q[7:4] - 4'd1, 4'd9};
      end else if (!time_zero_c) begin
         dec_sec_c = 8'h59;
         if (min_q[3:0] != 4'd0) begin
            dec_min_c[3:0] = min_q[3:0] - 4'd1;
         end else begin
            dec_min_c = {min_q[7:4] - 4'd1, 4'd9};
         end
      end
   end

   assign dec_zero_c = (dec_min_c == 8'h00) && (dec_sec_c == 8'h00);

   // Timer FSM: command priority load > start > pause > second tick
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         min_q     <= START_MIN;
         sec_q     <= START_SEC;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         clk1_q    <= 1'b1;
      end else begin
         clk1_q <= clock_1;
         if (load) begin
            if (load_ok_c) begin
               min_q     <= load_min;
               sec_q     <= load_sec;
               state_q   <= IDLE;
               running_q <= 1'b0;
               done_q    <= 1'b0;
            end
         end else if (start) begin
            if ((state_q == IDLE || state_q == PAUSE) && !time_zero_c) begin
               state_q   <= RUN;
               running_q <= 1'b1;
            end
         end else if (pause) begin
            if (state_q == RUN) begin
               state_q   <= PAUSE;
               running_q <= 1'b0;
            end
         end else if (tick_c && state_q == RUN) begin
            min_q <= dec_min_c;
            sec_q <= dec_sec_c;
            if (dec_zero_c) begin
               state_q   <= DONE;
               running_q <= 1'b0;
               done_q    <= 1'b1;
            end
         end
      end
   end

   assign min_bcd = min_q;
   assign sec_bcd = sec_q;
   assign running = running_q;
   assign done    = done_q;

`ifdef COUNTDOWN_ALARM_EN
   localparam int unsigned ACW = (ALARM_SECS < 2) ? 1 : $clog2(ALARM_SECS);

   logic [ACW-1:0] acnt_q;
   logic           alarm_q;

   // Alarm: raised on expiry, toggles once per second in DONE, then held low
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         alarm_q <= 1'b0;
         acnt_q  <= '0;
      end else if (load) begin
         if (load_ok_c) begin
            alarm_q <= 1'b0;
            acnt_q  <= '0;
         end
      end else if (tick_c) begin
         if (state_q == RUN && dec_zero_c) begin
            alarm_q <= 1'b1;
            acnt_q  <= '0;
         end else if (state_q == DONE) begin
            if (int'(acnt_q) + 1 < ALARM_SECS) begin
               alarm_q <= ~alarm_q;
               acnt_q  <= acnt_q + ACW'(1);
            end else begin
               alarm_q <= 1'b0;
            end
         end
      end
   end

   assign alarm = alarm_q;
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table vectors, directed corner sequences and a randomized run
// checked against a seconds-count reference model of the countdown timer.
module tb_countdown_timer;

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_DONE  = 3;
   localparam int ALARM_N = 4;
`ifdef COUNTDOWN_ALARM_EN
   localparam bit ALARM_EN = 1'b1;
`else
   localparam bit ALARM_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       clock_1;
   logic       start;
   logic       pause;
   logic       load;
   logic [7:0] load_min;
   logic [7:0] load_sec;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       running;
   logic       done;
   logic       alarm;

   int checks = 0;
   int errors = 0;

   // Reference model state: remaining time as a plain count of seconds
   int m_secs;
   int m_st;
   int m_npulse;
   bit m_c1d;
   bit m_alarm;

   typedef struct {
      logic       st;
      logic       pa;
      logic       ld;
      logic       c1;
      logic [7:0] lm;
      logic [7:0] ls;
      logic [7:0] emin;
      logic [7:0] esec;
      logic       erun;
      logic       edone;
   } vec_t;

   vec_t tbl [16];

   countdown_timer #(
      .START_MIN (8'h01),
      .START_SEC (8'h00),
      .ALARM_SECS(ALARM_N)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .clock_1 (clock_1),
      .start   (start),
      .pause   (pause),
      .load    (load),
      .load_min(load_min),
      .load_sec(load_sec),
      .min_bcd (min_bcd),
      .sec_bcd (sec_bcd),
      .running (running),
      .done    (done),
      .alarm   (alarm)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] int2bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int bcd2int(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit bcd_ok(input logic [7:0] lm, input logic [7:0] ls);
      return (lm[7:4] <= 9) && (lm[3:0] <= 9) && (ls[7:4] <= 5) && (ls[3:0] <= 9);
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [7:0] emin, input logic [7:0] esec,
                          input logic erun, input logic edone, input logic eal);
      check({nm, "_min"},     16'(min_bcd), 16'(emin));
      check({nm, "_sec"},     16'(sec_bcd), 16'(esec));
      check({nm, "_running"}, 16'(running), 16'(erun));
      check({nm, "_done"},    16'(done),    16'(edone));
      check({nm, "_alarm"},   16'(alarm),   16'(eal));
   endtask

   task automatic check_model(input string nm);
      chk_out(nm, int2bcd(m_secs / 60), int2bcd(m_secs % 60),
              m_st == S_RUN, m_st == S_DONE, ALARM_EN & m_alarm);
   endtask

   task automatic model_reset();
      m_secs   = 60;
      m_st     = S_IDLE;
      m_c1d    = 1'b1;
      m_alarm  = 1'b0;
      m_npulse = 0;
   endtask

   // Advance the model by one clock using the inputs the DUT just sampled
   task automatic model_step();
      bit pulse;
      pulse = clock_1 && !m_c1d;
      m_c1d = clock_1;
      if (load) begin
         if (bcd_ok(load_min, load_sec)) begin
            m_secs  = bcd2int(load_min) * 60 + bcd2int(load_sec);
            m_st    = S_IDLE;
            m_alarm = 1'b0;
         end
      end else if (start) begin
         if ((m_st == S_IDLE || m_st == S_PAUSE) && m_secs != 0) m_st = S_RUN;
      end else if (pause) begin
         if (m_st == S_RUN) m_st = S_PAUSE;
      end else if (pulse) begin
         if (m_st == S_RUN) begin
            m_secs--;
            if (m_secs == 0) begin
               m_st     = S_DONE;
               m_alarm  = 1'b1;
               m_npulse = 0;
            end
         end else if (m_st == S_DONE) begin
            m_npulse++;
            m_alarm = (m_npulse < ALARM_N) && (m_npulse % 2 == 0);
         end
      end
   endtask

   task automatic cyc(input logic st, input logic pa, input logic ld, input logic c1,
                      input logic [7:0] lm, input logic [7:0] ls);
      start    = st;
      pause    = pa;
      load     = ld;
      clock_1  = c1;
      load_min = lm;
      load_sec = ls;
      @(posedge clock);
      #1;
      model_step();
   endtask

   task automatic sec_tick();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
   endtask

   task automatic do_reset(input string nm);
      start = 1'b0;
      pause = 1'b0;
      load  = 1'b0;
      reset = 1'b1;
      #1;
      model_reset();
      chk_out(nm, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 8'h00, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h09, 8'h59, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h09, 8'h59, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 8'h00, 8'h10, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h10, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h09, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h09, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h6A, 8'h00, 8'h09, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hA0, 8'h00, 8'h00, 8'h09, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 8'h00, 8'h07, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h07, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h07, 1'b0, 1'b0};

      clock_1  = 1'b0;
      load_min = 8'h00;
      load_sec = 8'h00;
      do_reset("reset");

      // Full minute countdown from the reset value
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk_out("start", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 60; i++) begin
         sec_tick();
         check_model($sformatf("cnt%0d", i));
         if (i == 1) chk_out("cnt_first", 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);
      end
      chk_out("cnt_end", 8'h00, 8'h00, 1'b0, 1'b1, ALARM_EN);

      // Alarm sequence after expiry, then stays low
      for (int i = 1; i <= 6; i++) begin
         sec_tick();
         chk_out($sformatf("alarm_p%0d", i), 8'h00, 8'h00, 1'b0, 1'b1, ALARM_EN && (i == 2));
      end

      // Load during an active alarm clears it immediately
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      sec_tick();
      sec_tick();
      chk_out("al_entry", 8'h00, 8'h00, 1'b0, 1'b1, ALARM_EN);
      sec_tick();
      sec_tick();
      chk_out("al_mid", 8'h00, 8'h00, 1'b0, 1'b1, ALARM_EN);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05);
      chk_out("al_load", 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);

      // Table-driven vectors: borrow chains, invalid loads, zero start, idle ticks
      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].st, tbl[i].pa, tbl[i].ld, tbl[i].c1, tbl[i].lm, tbl[i].ls);
         chk_out($sformatf("vec%0d", i), tbl[i].emin, tbl[i].esec, tbl[i].erun,
                 tbl[i].edone, 1'b0);
      end

      // Pause coincident with a second edge drops that second
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h31);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      chk_out("p_run", 8'h00, 8'h30, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
      chk_out("p_pause", 8'h00, 8'h30, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk_out("p_resume", 8'h00, 8'h30, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      chk_out("p_next", 8'h00, 8'h29, 1'b1, 1'b0, 1'b0);

      // Reset mid-count with clock_1 held high: no spurious tick after release
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h06);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      chk_out("r_pre", 8'h00, 8'h05, 1'b1, 1'b0, 1'b0);
      do_reset("r_mid");
      chk_out("r_rel", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      chk_out("r_hold", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
      sec_tick();
      chk_out("r_tick", 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);

      // Randomized commands and 1 Hz edges against the reference model
      for (int i = 0; i < 3000; i++) begin
         logic       st;
         logic       pa;
         logic       ld;
         logic       c1;
         logic [7:0] lm;
         logic [7:0] ls;
         int         r;
         r  = int'($urandom_range(0, 99));
         ld = (r < 2);
         st = (r >= 2 && r < 10);
         pa = (r >= 10 && r < 12);
         c1 = clock_1;
         if ($urandom_range(0, 1) == 0) c1 = ~clock_1;
         lm = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
         ls = int2bcd(int'($urandom_range(0, 20)));
         if ($urandom_range(0, 4) == 0) ls = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) lm = 8'($urandom_range(0, 255));
         cyc(st, pa, ld, c1, lm, ls);
         check_model($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter START_MIN, default 8'h01, BCD minutes loaded at reset.
REQ-002 SHALL have parameter START_SEC, default 8'h00, BCD seconds loaded at reset.
REQ-003 SHALL have parameter ALARM_SECS, default 10, number of alarm seconds after expiry; used only with COUNTDOWN_ALARM_EN.
REQ-004 SHALL have port: clock  input  1  system clock, same clock that drives the 1 Hz divider.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: clock_1  input  1  1 Hz square wave from the divider; each rising edge is one second.
REQ-007 SHALL have port: start  input  1  level sampled each clock; requests counting.
REQ-008 SHALL have port: pause  input  1  level sampled each clock; suspends counting.
REQ-009 SHALL have port: load  input  1  level sampled each clock; loads load_min/load_sec.
REQ-010 SHALL have ports: load_min, load_sec  input  8  BCD values for load.
REQ-011 SHALL have ports: min_bcd, sec_bcd  output  8  registered BCD remaining time.
REQ-012 SHALL have ports: running, done, alarm  output  1  registered status outputs.

Function
REQ-013 SHALL register clock_1 into clock_1_d; sec_pulse = clock_1 AND NOT clock_1_d (one clock wide).
REQ-014 SHALL implement states IDLE, RUN, PAUSE, DONE; running = 1 only in RUN; done = 1 only in DONE.
REQ-015 Command priority, evaluated per clock: load > start > pause > sec_pulse.
REQ-016 load with valid BCD (min digits 0-9 each; sec tens 0-5, units 0-9) in any state: time <= load values, state -> IDLE, done = 0, alarm = 0.
REQ-017 load with invalid BCD: entire command ignored; time and state unchanged.
REQ-018 start in IDLE or PAUSE with time != 00:00: state -> RUN. With time == 00:00, state stays IDLE.
REQ-019 start in RUN or DONE: no effect.
REQ-020 pause in RUN: state -> PAUSE. In any other state: no effect.
REQ-021 sec_pulse in RUN (no higher-priority command): decrement time on that same clock edge, with no extra latency.
REQ-022 Decrement rules:
- sec units 0 -> 9 with borrow from sec tens.
- sec 00 -> 59 with borrow from minutes.
- min units 0 -> 9 with borrow from min tens.
- Result stays within 00:00-99:59.
REQ-023 When a decrement yields 00:00: state -> DONE on the same edge; done = 1 from that edge.
REQ-024 sec_pulse in IDLE, PAUSE or DONE: time unchanged.
REQ-025 A sec_pulse coincident with start, pause or load SHALL be discarded; it is not deferred.
REQ-026 DONE SHALL be left only by load or reset.

Reset
REQ-027 On reset, asynchronously and independent of the clock:
- min_bcd = START_MIN, sec_bcd = START_SEC.
- state = IDLE; running = 0, done = 0, alarm = 0.
- clock_1_d = 1, so that a high clock_1 at reset release does not create a pulse.
REQ-028 Reset asserted mid-count SHALL abort the countdown; no decrement occurs on the release edge.

Configuration
REQ-029 Macro COUNTDOWN_ALARM_EN defined:
- On entry to DONE, alarm = 1.
- alarm toggles on each sec_pulse while in DONE, for ALARM_SECS pulses, then holds 0.
- State remains DONE.
- load clears alarm immediately.
REQ-030 COUNTDOWN_ALARM_EN undefined: the alarm port exists and is constant 0; no alarm counter is synthesised.

Verification
REQ-031 Reset with START 01:00, start = 1 for one clock, 60 clock_1 edges -> 00:59 ... 00:00; done = 1 and running = 0 on the 60th edge.
REQ-032 load 10:00, start, one clock_1 edge -> 09:59; load 00:10, start, one edge -> 00:09 (borrow chains).
REQ-033 Running at 00:30, pause coincident with a sec_pulse -> stays 00:30, state PAUSE; start, next edge -> 00:29.
REQ-034 load_sec = 8'h6A -> ignored, time unchanged; load 00:00 then start -> stays IDLE, running = 0.
REQ-035 Reset asserted at 00:05 while clock_1 is high, then released -> START value, IDLE, no decrement until the next full low-high edge of clock_1.
REQ-036 With COUNTDOWN_ALARM_EN and ALARM_SECS = 4, expiry -> alarm 1,0,1,0 then 0 after 4 pulses; load mid-alarm -> alarm 0 at once.
